// File: rtl/common_types.sv
// Shared 6502 core types and constants: data/address widths, memory
// direction, interrupt-sequencer states and the fixed vector addresses.
package common_types;

    typedef logic [7:0]  data_t;
    typedef logic [15:0] addr_t;

    typedef enum logic {
        MwRead  = 1'b0,
        MwWrite = 1'b1
    } mw_t;

    typedef enum logic [2:0] {
        StReset,
        StIdle,
        StPushPch,
        StPushPcl,
        StPushP,
        StVecLo,
        StVecHi,
        StLoad
    } irq_state_t;

    localparam addr_t VEC_NMI    = 16'hFFFA;
    localparam addr_t VEC_RES    = 16'hFFFC;
    localparam addr_t VEC_IRQ    = 16'hFFFE;
    localparam data_t STACK_PAGE = 8'h01;

    localparam int unsigned P_B = 4;
    localparam int unsigned P_U = 5;

    // Status byte as stored on the stack: U always set, B marks a BRK entry.
    function automatic data_t push_status(data_t p, logic is_brk);
        data_t r;
        r      = p;
        r[P_U] = 1'b1;
        r[P_B] = is_brk;
        return r;
    endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Latches a falling edge on nmi_n into a pending flag that holds until
// the sequencer commits to the NMI vector.
module nmi_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_n,
    input  logic clr,
    output logic pend
);

    logic prev_q, prev_d;
    logic pend_q, pend_d;

    always_comb begin
        prev_d = nmi_n;
        pend_d = pend_q;
        if (clr) begin
            pend_d = 1'b0;
        end
        // A fresh edge wins over a same-cycle clear so it is never lost.
        if (prev_q && !nmi_n) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Runs the 6502 reset/NMI/IRQ/BRK entry: three stack pushes, a two-byte
// vector fetch and the PC reload with I set. Owns the memory port while req=1.
module interrupt_sequencer
    import common_types::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  nmi_n,
    input  logic  irq_n,
    input  logic  i_flag,
    input  logic  inst_boundary,
    input  logic  brk,
    input  addr_t pc,
    input  data_t p,
    input  data_t sp,
    input  data_t din,
    output logic  req,
    output addr_t addr,
    output data_t dout,
    output mw_t   mw,
    output logic  sp_dec,
    output logic  pc_load,
    output addr_t pc_new,
    output logic  set_i
);

    irq_state_t state_q, state_d;
    logic       is_reset_q, is_reset_d;
    logic       is_brk_q, is_brk_d;
    addr_t      pc_save_q, pc_save_d;
    addr_t      vec_q, vec_d;
    data_t      lo_q, lo_d;

    logic nmi_pend;
    logic nmi_clr;
    logic irq_take;

    nmi_edge_detect u_nmi_edge_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .nmi_n (nmi_n),
        .clr   (nmi_clr),
        .pend  (nmi_pend)
    );

    assign irq_take = inst_boundary && !irq_n && !i_flag;

    always_comb begin
        state_d    = state_q;
        is_reset_d = is_reset_q;
        is_brk_d   = is_brk_q;
        pc_save_d  = pc_save_q;
        vec_d      = vec_q;
        lo_d       = lo_q;
        nmi_clr    = 1'b0;

        unique case (state_q)
            StReset: begin
                state_d    = StPushPch;
                is_reset_d = 1'b1;
                is_brk_d   = 1'b0;
            end
            StIdle: begin
                // NMI > BRK > IRQ when several are present in the same cycle.
                if (inst_boundary && nmi_pend) begin
                    state_d    = StPushPch;
                    is_reset_d = 1'b0;
                    is_brk_d   = 1'b0;
                    pc_save_d  = pc;
                end else if (brk) begin
                    state_d    = StPushPch;
                    is_reset_d = 1'b0;
                    is_brk_d   = 1'b1;
                    pc_save_d  = pc;
                end else if (irq_take) begin
                    state_d    = StPushPch;
                    is_reset_d = 1'b0;
                    is_brk_d   = 1'b0;
                    pc_save_d  = pc;
                end
            end
            StPushPch: state_d = StPushPcl;
            StPushPcl: state_d = StPushP;
            StPushP: begin
                // Late vector choice lets an NMI hijack a BRK/IRQ already pushing.
                state_d = StVecLo;
                if (is_reset_q) begin
                    vec_d = VEC_RES;
                end else if (nmi_pend) begin
                    vec_d   = VEC_NMI;
                    nmi_clr = 1'b1;
                end else begin
                    vec_d = VEC_IRQ;
                end
            end
            StVecLo: state_d = StVecHi;
            StVecHi: begin
                state_d = StLoad;
                lo_d    = din;
            end
            StLoad:  state_d = StIdle;
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        req     = 1'b0;
        addr    = '0;
        dout    = '0;
        mw      = MwRead;
        sp_dec  = 1'b0;
        pc_load = 1'b0;
        pc_new  = '0;
        set_i   = 1'b0;

        unique case (state_q)
            StReset: req = 1'b1;
            StPushPch, StPushPcl, StPushP: begin
                req    = 1'b1;
                addr   = {STACK_PAGE, sp};
                sp_dec = 1'b1;
                // Reset walks the stack pointer with dummy reads only.
                if (!is_reset_q) begin
                    mw = MwWrite;
                    if (state_q == StPushPch) begin
                        dout = pc_save_q[15:8];
                    end else if (state_q == StPushPcl) begin
                        dout = pc_save_q[7:0];
                    end else begin
                        dout = push_status(p, is_brk_q);
                    end
                end
            end
            StVecLo: begin
                req  = 1'b1;
                addr = vec_q;
            end
            StVecHi: begin
                req  = 1'b1;
                addr = vec_q + 16'd1;
            end
            StLoad: begin
                pc_load = 1'b1;
                set_i   = 1'b1;
                pc_new  = {din, lo_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReset;
            is_reset_q <= 1'b1;
            is_brk_q   <= 1'b0;
            pc_save_q  <= '0;
            vec_q      <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            is_reset_q <= is_reset_d;
            is_brk_q   <= is_brk_d;
            pc_save_q  <= pc_save_d;
            vec_q      <= vec_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus queues the expected bus
// cycles and PC reloads; a negedge monitor pops and compares them.
module tb_interrupt_sequencer;
    import common_types::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  nmi_n = 1'b1;
    logic  irq_n = 1'b1;
    logic  i_flag = 1'b1;
    logic  inst_boundary = 1'b0;
    logic  brk = 1'b0;
    addr_t pc = '0;
    data_t p = '0;
    data_t sp;
    data_t din;
    logic  req, sp_dec, pc_load, set_i;
    addr_t addr, pc_new;
    data_t dout;
    mw_t   mw;

    logic  sp_set = 1'b0;
    data_t sp_set_val = '0;
    data_t mem [0:65535];

    typedef struct {
        addr_t a;
        logic  wr;
        data_t d;
        logic  dec;
    } bus_t;

    bus_t  bus_q[$];
    addr_t load_q[$];
    int    n_run = 0;
    int    n_fail = 0;

    interrupt_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .nmi_n         (nmi_n),
        .irq_n         (irq_n),
        .i_flag        (i_flag),
        .inst_boundary (inst_boundary),
        .brk           (brk),
        .pc            (pc),
        .p             (p),
        .sp            (sp),
        .din           (din),
        .req           (req),
        .addr          (addr),
        .dout          (dout),
        .mw            (mw),
        .sp_dec        (sp_dec),
        .pc_load       (pc_load),
        .pc_new        (pc_new),
        .set_i         (set_i)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: SP follows sp_dec, memory read data lags address by a cycle.
    always @(posedge clk) begin
        if (sp_set) sp <= sp_set_val;
        else if (sp_dec) sp <= sp - 8'd1;
        din <= mem[addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bus_t  e;
        addr_t x;
        if (rst_n) begin
            if (req) begin
                if (bus_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_bus_cycle: got addr %h mw %0d, expected none",
                             addr, mw);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_addr", 32'(addr), 32'(e.a));
                    chk("bus_mw", 32'(mw), 32'(e.wr));
                    if (e.wr) chk("bus_dout", 32'(dout), 32'(e.d));
                    chk("bus_sp_dec", 32'(sp_dec), 32'(e.dec));
                end
            end else if (pc_load) begin
                if (load_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_pc_load: got pc_new %h, expected none", pc_new);
                end else begin
                    x = load_q.pop_front();
                    chk("pc_new", 32'(pc_new), 32'(x));
                    chk("set_i", 32'(set_i), 32'd1);
                end
            end else if (sp_dec) begin
                n_run++;
                n_fail++;
                $display("FAIL idle_sp_dec: got 1 expected 0");
            end
        end
    end

    task automatic exp_bus(input addr_t a, input logic wr, input data_t d, input logic dec);
        bus_t e;
        e = '{a: a, wr: wr, d: d, dec: dec};
        bus_q.push_back(e);
    endtask

    task automatic exp_int(input data_t s, input addr_t ret, input data_t pp,
                           input addr_t vec, input addr_t target);
        exp_bus({8'h01, s}, 1'b1, ret[15:8], 1'b1);
        exp_bus({8'h01, data_t'(s - 8'd1)}, 1'b1, ret[7:0], 1'b1);
        exp_bus({8'h01, data_t'(s - 8'd2)}, 1'b1, pp, 1'b1);
        exp_bus(vec, 1'b0, 8'h00, 1'b0);
        exp_bus(addr_t'(vec + 16'd1), 1'b0, 8'h00, 1'b0);
        load_q.push_back(target);
    endtask

    task automatic exp_reset(input data_t s, input addr_t target);
        exp_bus({8'h01, s}, 1'b0, 8'h00, 1'b1);
        exp_bus({8'h01, data_t'(s - 8'd1)}, 1'b0, 8'h00, 1'b1);
        exp_bus({8'h01, data_t'(s - 8'd2)}, 1'b0, 8'h00, 1'b1);
        exp_bus(16'hFFFC, 1'b0, 8'h00, 1'b0);
        exp_bus(16'hFFFD, 1'b0, 8'h00, 1'b0);
        load_q.push_back(target);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus_q.size() == 0 && load_q.size() == 0) break;
        end
        if (bus_q.size() != 0 || load_q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bus and %0d loads outstanding, expected 0",
                     name, bus_q.size(), load_q.size());
            bus_q.delete();
            load_q.delete();
        end
    endtask

    task automatic set_sp(input data_t v);
        @(negedge clk);
        sp_set = 1'b1;
        sp_set_val = v;
        @(negedge clk);
        sp_set = 1'b0;
    endtask

    task automatic pulse_ib();
        @(negedge clk);
        inst_boundary = 1'b1;
        @(negedge clk);
        inst_boundary = 1'b0;
    endtask

    initial begin
        mem[16'hFFFA] = 8'h11;
        mem[16'hFFFB] = 8'h22;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        mem[16'hFFFE] = 8'h78;
        mem[16'hFFFF] = 8'h56;

        // Reset state and power-on sequence
        set_sp(8'hFD);
        @(negedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd1);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_mw", 32'(mw), 32'(MwRead));
        chk("rst_sp_dec", 32'(sp_dec), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_pc_new", 32'(pc_new), 32'd0);
        chk("rst_set_i", 32'(set_i), 32'd0);
        exp_reset(8'hFD, 16'h8000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_drain("reset_seq");

        // IRQ taken
        set_sp(8'hFF);
        pc = 16'h1234;
        p = 8'h00;
        irq_n = 1'b0;
        i_flag = 1'b0;
        exp_int(8'hFF, 16'h1234, 8'h20, 16'hFFFE, 16'h5678);
        pulse_ib();
        irq_n = 1'b1;
        wait_drain("irq_seq");

        // IRQ masked
        set_sp(8'hFF);
        irq_n = 1'b0;
        i_flag = 1'b1;
        pulse_ib();
        repeat (8) @(negedge clk);
        #1;
        chk("masked_req", 32'(req), 32'd0);
        chk("masked_sp", 32'(sp), 32'hFF);
        irq_n = 1'b1;

        // BRK ignores I, pushes B=1
        pc = 16'hC000;
        p = 8'h04;
        exp_int(8'hFF, 16'hC000, 8'h34, 16'hFFFE, 16'h5678);
        @(negedge clk);
        brk = 1'b1;
        @(negedge clk);
        brk = 1'b0;
        wait_drain("brk_seq");

        // NMI hijacks BRK; second edge during VEC_HI stays pending
        set_sp(8'hFF);
        pc = 16'hABCD;
        p = 8'h00;
        exp_int(8'hFF, 16'hABCD, 8'h30, 16'hFFFA, 16'h2211);
        @(negedge clk);
        brk = 1'b1;
        @(negedge clk);
        brk = 1'b0;
        @(negedge clk);
        nmi_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nmi_n = 1'b1;
        @(negedge clk);
        nmi_n = 1'b0;
        wait_drain("hijack_seq");
        pc = 16'h2211;
        exp_int(8'hFC, 16'h2211, 8'h20, 16'hFFFA, 16'h2211);
        pulse_ib();
        wait_drain("nmi_second_seq");
        pulse_ib();
        repeat (8) @(negedge clk);
        #1;
        chk("nmi_pend_cleared_sp", 32'(sp), 32'hF9);
        nmi_n = 1'b1;

        // Reset during PUSH_P aborts and drops the pending NMI
        set_sp(8'hFF);
        pc = 16'h4321;
        irq_n = 1'b0;
        i_flag = 1'b0;
        exp_bus(16'h01FF, 1'b1, 8'h43, 1'b1);
        exp_bus(16'h01FE, 1'b1, 8'h21, 1'b1);
        pulse_ib();
        irq_n = 1'b1;
        nmi_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(req), 32'd1);
        chk("abort_mw", 32'(mw), 32'(MwRead));
        chk("abort_pc_load", 32'(pc_load), 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_queue", 32'(bus_q.size()), 32'd0);
        nmi_n = 1'b1;
        set_sp(8'hFD);
        exp_reset(8'hFD, 16'h8000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_drain("abort_reset_seq");
        pulse_ib();
        repeat (8) @(negedge clk);
        #1;
        chk("abort_nmi_cleared_sp", 32'(sp), 32'hFA);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
